// File: rtl/lcd_fill_sequencer.sv
// Rectangle-fill bus master for the ST7789 register block: programs colour once,
// then window + pixel-write per pixel in row-major order, polling status between pixels.
module lcd_fill_sequencer #(
  parameter int          AW      = 11,
  parameter logic [15:0] SPI_DIV = 16'd0,
  parameter int          TIMEOUT = 4096
) (
  input  logic          up_clk,
  input  logic          up_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [15:0]   cmd_x0,
  input  logic [15:0]   cmd_y0,
  input  logic [15:0]   cmd_x1,
  input  logic [15:0]   cmd_y1,
  input  logic [15:0]   cmd_color,
  input  logic          cmd_abort,
  output logic          done,
  output logic          err,
  output logic          busy,
  output logic [31:0]   pix_cnt,
  output logic          m_wreq,
  output logic [AW:0]   m_waddr,
  output logic [31:0]   m_wdata,
  input  logic          m_wack,
  output logic          m_rreq,
  output logic [AW:0]   m_raddr,
  input  logic [31:0]   m_rdata,
  input  logic          m_rack
);

  localparam logic [AW:0] ADDR_CFG    = (AW+1)'(0);
  localparam logic [AW:0] ADDR_STATUS = (AW+1)'(1);
  localparam logic [AW:0] ADDR_ADDRH  = (AW+1)'(2);
  localparam logic [AW:0] ADDR_ADDRL  = (AW+1)'(3);
  localparam logic [AW:0] ADDR_COLOR  = (AW+1)'(4);
  localparam logic [31:0] TIMEOUT_W   = 32'(TIMEOUT);

  typedef enum logic [3:0] {
    WAIT_INIT,
    IDLE,
    WR_COLOR,
    WR_ADDRH,
    WR_ADDRL,
    WR_CFG,
    POLL_LO,
    POLL_HI,
    NEXT
  } state_t;

  state_t      state;
  state_t      wr_next;
  logic [AW:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] x, y, x0, x1, y1, color;
  logic        abort_pend;
  logic        issued;
  logic [31:0] poll_cnt;
  logic        poll_expired;
  logic        abort_now;
  logic        last_pixel;
  logic        unused_rdata;

  assign poll_expired = (poll_cnt + 32'd1) >= TIMEOUT_W;
  assign abort_now    = abort_pend | cmd_abort;
  assign last_pixel   = (x == x1) && (y == y1);
  assign unused_rdata = ^{m_rdata[31:6], m_rdata[2:0]};

  // Address, data and successor for whichever register write the current state performs.
  always_comb begin
    wr_addr = ADDR_CFG;
    wr_data = 32'd0;
    wr_next = IDLE;
    case (state)
      WR_COLOR: begin
        wr_addr = ADDR_COLOR;
        wr_data = {16'd0, color};
        wr_next = WR_ADDRH;
      end
      WR_ADDRH: begin
        wr_addr = ADDR_ADDRH;
        wr_data = {x, y};
        wr_next = WR_ADDRL;
      end
      WR_ADDRL: begin
        wr_addr = ADDR_ADDRL;
        wr_data = {x, y};
        wr_next = WR_CFG;
      end
      WR_CFG: begin
        wr_addr = ADDR_CFG;
        wr_data = {SPI_DIV, 16'h0001};
        wr_next = POLL_LO;
      end
      default: ;
    endcase
  end

  // Each bus state first raises its request for one cycle, then waits for the ack;
  // 'issued' separates those two halves so a new request never overlaps an open one.
  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      state      <= WAIT_INIT;
      cmd_ready  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      pix_cnt    <= 32'd0;
      m_wreq     <= 1'b0;
      m_waddr    <= '0;
      m_wdata    <= 32'd0;
      m_rreq     <= 1'b0;
      m_raddr    <= '0;
      x          <= 16'd0;
      y          <= 16'd0;
      x0         <= 16'd0;
      x1         <= 16'd0;
      y1         <= 16'd0;
      color      <= 16'd0;
      abort_pend <= 1'b0;
      issued     <= 1'b0;
      poll_cnt   <= 32'd0;
    end else begin
      m_wreq <= 1'b0;
      m_rreq <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      if (cmd_abort && state != IDLE && state != WAIT_INIT)
        abort_pend <= 1'b1;

      case (state)
        IDLE: begin
          busy       <= 1'b0;
          cmd_ready  <= 1'b1;
          abort_pend <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            pix_cnt   <= 32'd0;
            x0        <= cmd_x0;
            x1        <= cmd_x1;
            y1        <= cmd_y1;
            color     <= cmd_color;
            x         <= cmd_x0;
            y         <= cmd_y0;
            if (cmd_x1 < cmd_x0 || cmd_y1 < cmd_y0) begin
              err <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= WR_COLOR;
            end
          end
        end

        WR_COLOR, WR_ADDRH, WR_ADDRL, WR_CFG: begin
          if (!issued) begin
            m_wreq  <= 1'b1;
            m_waddr <= wr_addr;
            m_wdata <= wr_data;
            issued  <= 1'b1;
          end else if (m_wack) begin
            issued   <= 1'b0;
            poll_cnt <= 32'd0;
            state    <= wr_next;
          end
        end

        WAIT_INIT, POLL_LO, POLL_HI: begin
          if (!issued) begin
            m_rreq  <= 1'b1;
            m_raddr <= ADDR_STATUS;
            issued  <= 1'b1;
          end else if (m_rack) begin
            issued <= 1'b0;
            if (state == WAIT_INIT) begin
              if (m_rdata[3])
                state <= IDLE;
            end else if ((state == POLL_LO && !m_rdata[5]) ||
                         (state == POLL_HI && m_rdata[5] && !m_rdata[4])) begin
              poll_cnt <= 32'd0;
              state    <= (state == POLL_LO) ? POLL_HI : NEXT;
            end else if (poll_expired) begin
              err        <= 1'b1;
              abort_pend <= 1'b0;
              state      <= IDLE;
            end else begin
              poll_cnt <= poll_cnt + 32'd1;
            end
          end
        end

        NEXT: begin
          pix_cnt    <= pix_cnt + 32'd1;
          abort_pend <= 1'b0;
          if (abort_now || last_pixel) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            // Compare before increment so a corner at 16'hFFFF ends instead of wrapping.
            if (x == x1) begin
              x <= x0;
              y <= y + 16'd1;
            end else begin
              x <= x + 16'd1;
            end
            state <= WR_ADDRH;
          end
        end

        default: state <= WAIT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_fill_sequencer.sv
// Self-checking bench: randomised-latency LCD register model plus a row-major
// reference of the register writes each fill command should produce.
module tb_lcd_fill_sequencer;

  localparam int AW = 11;
  localparam int TO = 8;

  logic          up_clk = 1'b0;
  logic          up_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [15:0]   cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0, cmd_color = '0;
  logic          cmd_abort = 1'b0;
  logic          done, err, busy;
  logic [31:0]   pix_cnt;
  logic          m_wreq, m_rreq;
  logic [AW:0]   m_waddr, m_raddr;
  logic [31:0]   m_wdata;
  logic          m_wack = 1'b0;
  logic          m_rack = 1'b0;
  logic [31:0]   m_rdata = 32'd0;

  lcd_fill_sequencer #(.AW(AW), .SPI_DIV(16'd0), .TIMEOUT(TO)) dut (
    .up_clk(up_clk), .up_rst(up_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .cmd_abort(cmd_abort),
    .done(done), .err(err), .busy(busy), .pix_cnt(pix_cnt),
    .m_wreq(m_wreq), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wack(m_wack),
    .m_rreq(m_rreq), .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rack(m_rack)
  );

  always #5 up_clk = ~up_clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge up_clk) cyc <= cyc + 1;

  // LCD register block model state
  logic [43:0] wlog[$];
  logic [43:0] exp_q[$];
  int  rd_count = 0, poll_reads = 0, cfg_writes = 0, violations = 0;
  int  init_left = 100, init_ack_cyc = 0;
  bit  init_seen = 0, never_done = 0;
  int  lo_left = 0, busy_left = 0, hb_left = 0;
  bit  w_active = 0, r_active = 0;
  int  w_wait = 0, r_wait = 0;
  logic [AW:0] w_addr_h;
  logic [31:0] w_data_h;

  function automatic logic [31:0] status_word();
    logic [31:0] w;
    w = $urandom;
    w[5:3] = 3'b000;
    rd_count++;
    poll_reads++;
    if (init_left > 0) begin
      init_left--;
    end else begin
      w[3] = 1'b1;
      if (!init_seen) begin
        init_seen = 1;
        init_ack_cyc = cyc;
      end
      if (never_done) w[5] = 1'b1;
      else if (lo_left > 0) begin lo_left--; w[5] = 1'b1; end
      else if (busy_left > 0) begin busy_left--; w[4] = 1'b1; end
      else if (hb_left > 0) begin hb_left--; w[5] = 1'b1; w[4] = 1'b1; end
      else w[5] = 1'b1;
    end
    return w;
  endfunction

  // Slave responds mid-cycle so the DUT sees stable acks at its next rising edge.
  always @(negedge up_clk) begin
    bit bus_open;
    m_wack = 1'b0;
    m_rack = 1'b0;
    if (up_rst) begin
      w_active = 0;
      r_active = 0;
      lo_left = 0;
      busy_left = 0;
      hb_left = 0;
    end else begin
      bus_open = w_active || r_active;
      if (m_wreq && m_rreq) violations++;
      if (m_wreq) begin
        if (bus_open) violations++;
        if (m_waddr == 2 && !never_done && (lo_left + busy_left + hb_left) != 0) violations++;
        wlog.push_back({m_waddr, m_wdata});
        if (m_waddr == 0 && m_wdata[0]) begin
          cfg_writes++;
          poll_reads = 0;
          lo_left = $urandom_range(0, 2);
          busy_left = $urandom_range(1, 3);
          hb_left = $urandom_range(0, 1);
        end
        w_active = 1;
        w_wait = $urandom_range(0, 2);
        w_addr_h = m_waddr;
        w_data_h = m_wdata;
      end else if (w_active && (m_waddr !== w_addr_h || m_wdata !== w_data_h)) begin
        violations++;
      end
      if (m_rreq) begin
        if (bus_open || m_raddr != 1) violations++;
        r_active = 1;
        r_wait = $urandom_range(0, 2);
      end
      if (w_active) begin
        if (w_wait == 0) begin m_wack = 1'b1; w_active = 0; end
        else w_wait--;
      end
      if (r_active) begin
        if (r_wait == 0) begin m_rack = 1'b1; r_active = 0; m_rdata = status_word(); end
        else r_wait--;
      end
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!cmd_ready && k < 3000) begin
      @(posedge up_clk); #1;
      k++;
    end
    check_output(tag, cmd_ready, 1'b1);
  endtask

  // Drives one fill command and checks termination, pulses, busy, pix_cnt and the write stream.
  task automatic apply_stimulus(input string name, input logic [15:0] x0, input logic [15:0] y0,
                                input logic [15:0] x1, input logic [15:0] y1, input logic [15:0] col,
                                input int abort_at, input bit expect_timeout);
    bit reject, seen, got_done, got_err, busy_bad, aborted;
    int area, exp_pix, wr_pix, n, rd0, cfg0;
    reject = (x1 < x0) || (y1 < y0);
    area = reject ? 0 : (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
    exp_pix = (abort_at > 0 && abort_at < area) ? abort_at : area;
    if (expect_timeout) exp_pix = 0;
    wr_pix = expect_timeout ? 1 : exp_pix;

    exp_q.delete();
    if (!reject) begin
      exp_q.push_back({12'd4, 16'd0, col});
      n = 0;
      for (int yy = int'(y0); yy <= int'(y1) && n < wr_pix; yy++)
        for (int xx = int'(x0); xx <= int'(x1) && n < wr_pix; xx++) begin
          exp_q.push_back({12'd2, 16'(xx), 16'(yy)});
          exp_q.push_back({12'd3, 16'(xx), 16'(yy)});
          exp_q.push_back({12'd0, 32'h0000_0001});
          n++;
        end
    end

    wait_ready({name, "_ready_in"});
    wlog.delete();
    rd0 = rd_count;
    cfg0 = cfg_writes;
    cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_color = col;
    cmd_valid = 1'b1;
    @(posedge up_clk); #1;
    cmd_valid = 1'b0;

    seen = 0; got_done = 0; got_err = 0; busy_bad = 0; aborted = 0;
    for (int k = 0; k < 5000; k++) begin
      if (busy !== !reject) busy_bad = 1;
      if (done || err) begin
        seen = 1;
        got_done = done;
        got_err = err;
        break;
      end
      if (abort_at > 0 && !aborted && (cfg_writes - cfg0) == abort_at) begin
        cmd_abort = 1'b1;
        aborted = 1;
      end
      @(posedge up_clk); #1;
      cmd_abort = 1'b0;
    end
    cmd_abort = 1'b0;

    check_output({name, "_terminated"}, seen, 1'b1);
    check_output({name, "_done"}, got_done, !reject && !expect_timeout);
    check_output({name, "_err"}, got_err, reject || expect_timeout);
    check_output({name, "_busy_window"}, busy_bad, 1'b0);
    check_output({name, "_pix_cnt"}, pix_cnt, exp_pix);

    @(posedge up_clk); #1;
    check_output({name, "_pulse_end"}, {done, err}, 2'b00);
    check_output({name, "_busy_after"}, busy, 1'b0);
    check_output({name, "_ready_after"}, cmd_ready, 1'b1);
    check_output({name, "_pix_hold"}, pix_cnt, exp_pix);

    check_output({name, "_wr_count"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      check_output($sformatf("%s_wr%0d", name, i), wlog[i], exp_q[i]);
    if (reject) check_output({name, "_no_reads"}, rd_count - rd0, 0);
    if (expect_timeout) check_output({name, "_poll_reads"}, poll_reads, TO);
    else if (!reject) check_output({name, "_status_drained"}, lo_left + busy_left + hb_left, 0);
    check_output({name, "_protocol"}, violations, 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rx0, ry0, rx1, ry1;
    int w, h;

    repeat (3) @(posedge up_clk);
    #1;
    check_output("rst_cmd_ready", cmd_ready, 1'b0);
    check_output("rst_pulses", {done, err, busy}, 3'b000);
    check_output("rst_reqs", {m_wreq, m_rreq}, 2'b00);
    check_output("rst_waddr", m_waddr, 0);
    check_output("rst_raddr", m_raddr, 0);
    check_output("rst_wdata", m_wdata, 0);
    check_output("rst_pix_cnt", pix_cnt, 0);
    check_output("rst_no_reads", rd_count, 0);

    @(negedge up_clk);
    up_rst = 1'b0;
    wait_ready("init_ready");
    check_output("init_seen_first", init_seen, 1'b1);
    check_output("init_read_count", rd_count, 101);
    check_output("init_latency_ok", (cyc - init_ack_cyc) <= 4, 1'b1);

    apply_stimulus("fill1x1", 16'd10, 16'd20, 16'd10, 16'd20, 16'hF800, 0, 0);
    apply_stimulus("fill3x2", 16'd0, 16'd0, 16'd2, 16'd1, 16'h07E0, 0, 0);
    apply_stimulus("reject", 16'd5, 16'd0, 16'd4, 16'd3, 16'h1234, 0, 0);
    apply_stimulus("reject_y", 16'd1, 16'd9, 16'd1, 16'd8, 16'h4321, 0, 0);
    apply_stimulus("abort", 16'd1, 16'd1, 16'd4, 16'd4, 16'h001F, 2, 0);
    apply_stimulus("xmax", 16'hFFFE, 16'd7, 16'hFFFF, 16'd7, 16'hAAAA, 0, 0);
    apply_stimulus("ymax", 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h5555, 0, 0);

    for (int it = 0; it < 6; it++) begin
      w = $urandom_range(1, 4);
      h = $urandom_range(1, 3);
      rx0 = 16'($urandom_range(0, 65536 - w));
      ry0 = 16'($urandom_range(0, 65536 - h));
      rx1 = rx0 + 16'(w - 1);
      ry1 = ry0 + 16'(h - 1);
      apply_stimulus($sformatf("rand%0d", it), rx0, ry0, rx1, ry1, 16'($urandom), 0, 0);
    end

    never_done = 1;
    apply_stimulus("timeout", 16'd3, 16'd4, 16'd3, 16'd4, 16'hBEEF, 0, 1);
    never_done = 0;
    lo_left = 0; busy_left = 0; hb_left = 0;

    wait_ready("midrst_ready_in");
    cmd_x0 = 16'd0; cmd_y0 = 16'd0; cmd_x1 = 16'd2; cmd_y1 = 16'd2; cmd_color = 16'hFFFF;
    cmd_valid = 1'b1;
    @(posedge up_clk); #1;
    cmd_valid = 1'b0;
    repeat (40) @(posedge up_clk);
    @(negedge up_clk); #2;
    up_rst = 1'b1;
    #1;
    check_output("midrst_ready", cmd_ready, 1'b0);
    check_output("midrst_flags", {done, err, busy}, 3'b000);
    check_output("midrst_reqs", {m_wreq, m_rreq}, 2'b00);
    check_output("midrst_bus", {m_waddr, m_wdata}, 44'd0);
    check_output("midrst_pix_cnt", pix_cnt, 0);
    init_left = 3;
    init_seen = 0;
    repeat (2) @(negedge up_clk);
    up_rst = 1'b0;
    wait_ready("midrst_reinit");
    check_output("midrst_init_seen", init_seen, 1'b1);
    apply_stimulus("after_rst", 16'd7, 16'd8, 16'd8, 16'd8, 16'h0F0F, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
